// File: rtl/uart_tx_word_framer_if.sv
// Word handshake between a result producer and the UART word framer.
// The producer holds word_in/word_valid until word_ready is seen high at a clock edge.
interface uart_tx_word_framer_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/uart_tx_word_framer.sv
// UART word framer: turns each accepted word into a byte frame
//   HEADER_BYTE, payload bytes MSB-first, XOR checksum of the payload
// and hands the bytes to the UART transmit core through a toggle-style start.
// A new word is taken only while the core reports idle, so the core FIFO
// never holds more than one frame.
module uart_tx_word_framer #(
  parameter int         WORD_WIDTH    = 16,
  parameter logic [7:0] HEADER_BYTE   = 8'hAA,
  parameter int         BYTE_GAP      = 2,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_word_framer_if.slave  word_bus,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  localparam int NB        = WORD_WIDTH / 8;
  localparam int FRAME_LEN = NB + 2;
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    GAP    = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t                state_r;
  logic [WORD_WIDTH-1:0] word_r;
  logic [IDX_W-1:0]      idx_r;
  logic [7:0]            csum_r;
  logic [7:0]            tx_data_r;
  logic                  tx_start_r;
  logic                  busy_r;
  logic [15:0]           cnt_r;
  logic [15:0]           frame_count_r;

  logic                  word_ready_s;
  logic                  accept_s;
  logic [WORD_WIDTH-1:0] shifted_s;
  logic [7:0]            byte_s;
  logic                  payload_s;

  // One step of the frame checksum: bytewise XOR
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  // Ready only when idle and the core has drained; forced low while in reset
  always_comb begin
    if (reset) begin
      word_ready_s = 1'b0;
    end else begin
      word_ready_s = (state_r == IDLE) && !tx_busy;
    end
  end

  assign word_bus.word_ready = word_ready_s;
  assign accept_s            = word_bus.word_valid && word_ready_s;

  // Select the byte for the current frame index (header, payload MSB-first, checksum)
  always_comb begin
    shifted_s = word_r << {idx_r - {{(IDX_W-1){1'b0}}, 1'b1}, 3'b000};
    byte_s    = 8'h00;
    payload_s = 1'b0;
    if (idx_r == IDX_W'(0)) begin
      byte_s = HEADER_BYTE;
    end else if (idx_r == IDX_W'(NB + 1)) begin
      byte_s = csum_r;
    end else begin
      byte_s    = shifted_s[WORD_WIDTH-1 -: 8];
      payload_s = 1'b1;
    end
  end

  // Frame sequencer: capture, emit one byte per BYTE_GAP cycles, settle, return to idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      word_r        <= {WORD_WIDTH{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      csum_r        <= 8'h00;
      tx_data_r     <= 8'h00;
      tx_start_r    <= 1'b0;
      busy_r        <= 1'b0;
      cnt_r         <= 16'd0;
      frame_count_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            word_r  <= word_bus.word_in;
            idx_r   <= {IDX_W{1'b0}};
            csum_r  <= 8'h00;
            busy_r  <= 1'b1;
            state_r <= EMIT;
          end
        end
        EMIT: begin
          tx_data_r  <= byte_s;
          tx_start_r <= ~tx_start_r;
          if (payload_s) begin
            csum_r <= csum_step(csum_r, byte_s);
          end
          idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          cnt_r   <= 16'(BYTE_GAP - 2);
          state_r <= GAP;
        end
        GAP: begin
          if (cnt_r == 16'd0) begin
            if (idx_r < IDX_W'(FRAME_LEN)) begin
              state_r <= EMIT;
            end else begin
              cnt_r         <= 16'(SETTLE_CYCLES - 1);
              frame_count_r <= frame_count_r + 16'd1;
              state_r       <= SETTLE;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        SETTLE: begin
          // Gives the core time to raise tx_busy for the bytes just queued
          if (cnt_r == 16'd0) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tx_data     = tx_data_r;
  assign tx_start    = tx_start_r;
  assign busy        = busy_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_uart_tx_word_framer.sv
// Directed bench for uart_tx_word_framer: a 16-bit/BYTE_GAP=2 instance and a
// 32-bit/BYTE_GAP=5 instance, with a byte scoreboard per instance.
module tb_uart_tx_word_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  // Edge counter: after the Nth rising edge cyc == N
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_word_framer_if #(.WORD_WIDTH(16)) bus_a ();
  uart_tx_word_framer_if #(.WORD_WIDTH(32)) bus_b ();

  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_start_a, tx_start_b;
  logic        tx_busy_a = 1'b0;
  logic        tx_busy_b;
  logic        busy_a, busy_b;
  logic [15:0] fc_a, fc_b;

  assign tx_busy_b = 1'b0;

  uart_tx_word_framer dut_a (
    .clk(clk), .reset(reset), .word_bus(bus_a),
    .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_busy(tx_busy_a),
    .busy(busy_a), .frame_count(fc_a)
  );

  uart_tx_word_framer #(.WORD_WIDTH(32), .HEADER_BYTE(8'hAA), .BYTE_GAP(5), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .word_bus(bus_b),
    .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_busy(tx_busy_b),
    .busy(busy_b), .frame_count(fc_b)
  );

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  int         start_q_a[$];
  int         start_q_b[$];

  // Transmit-core busy model: high for edges busy_lo <= cyc < busy_hi
  int busy_lo = 0;
  int busy_hi = 0;
  always @(negedge clk) tx_busy_a = (cyc >= busy_lo) && (cyc < busy_hi);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame_a(input logic [15:0] w);
    exp_q_a.push_back(8'hAA);
    exp_q_a.push_back(w[15:8]);
    exp_q_a.push_back(w[7:0]);
    exp_q_a.push_back(w[15:8] ^ w[7:0]);
  endfunction

  function automatic void push_frame_b(input logic [31:0] w);
    exp_q_b.push_back(8'hAA);
    exp_q_b.push_back(w[31:24]);
    exp_q_b.push_back(w[23:16]);
    exp_q_b.push_back(w[15:8]);
    exp_q_b.push_back(w[7:0]);
    exp_q_b.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
  endfunction

  // Scoreboard A: each tx_start level change pops one byte; tx_data must hold between toggles
  int         tog_a = 0, pos_a = 0, last_tog_a = 0;
  logic       prev_a = 1'b0;
  logic [7:0] last_a = 8'h00;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_a = tx_start_a;
      last_a = 8'h00;
      pos_a  = 0;
      exp_q_a.delete();
    end else if (tx_start_a !== prev_a) begin
      prev_a = tx_start_a;
      tog_a++;
      if (pos_a == 0) start_q_a.push_back(cyc);
      else check("gap_a", cyc - last_tog_a, 32'd2);
      last_tog_a = cyc;
      check("byte_expected_a", {31'b0, exp_q_a.size() > 0}, 32'd1);
      if (exp_q_a.size() > 0) begin
        last_a = exp_q_a.pop_front();
        check("byte_a", tx_data_a, last_a);
      end
      pos_a = (pos_a + 1) % 4;
    end else begin
      check("hold_a", tx_data_a, last_a);
    end
  end

  // Scoreboard B: same checks for the 32-bit, BYTE_GAP=5 instance
  int         pos_b = 0, last_tog_b = 0;
  logic       prev_b = 1'b0;
  logic [7:0] last_b = 8'h00;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_b = tx_start_b;
      last_b = 8'h00;
      pos_b  = 0;
      exp_q_b.delete();
    end else if (tx_start_b !== prev_b) begin
      prev_b = tx_start_b;
      if (pos_b == 0) start_q_b.push_back(cyc);
      else check("gap_b", cyc - last_tog_b, 32'd5);
      last_tog_b = cyc;
      check("byte_expected_b", {31'b0, exp_q_b.size() > 0}, 32'd1);
      if (exp_q_b.size() > 0) begin
        last_b = exp_q_b.pop_front();
        check("byte_b", tx_data_b, last_b);
      end
      pos_b = (pos_b + 1) % 6;
    end else begin
      check("hold_b", tx_data_b, last_b);
    end
  end

  task automatic present_a(input logic [15:0] w);
    push_frame_a(w);
    @(negedge clk);
    bus_a.word_in    = w;
    bus_a.word_valid = 1'b1;
  endtask

  // Returns the edge number at which the word was taken; ends on the following negedge
  task automatic wait_accept_a(output int acc);
    logic found;
    found = 1'b0;
    acc   = -1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (bus_a.word_ready === 1'b1) begin
        found = 1'b1;
        acc   = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    check("accept_a", {31'b0, found}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_a.word_valid = 1'b0;
    bus_a.word_in    = 16'hDEAD;
  endtask

  // Returns the first edge after which busy_a reads low
  task automatic wait_idle_a(output int e);
    logic found;
    found = 1'b0;
    e     = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (busy_a === 1'b0) begin
        found = 1'b1;
        e     = cyc;
        break;
      end
    end
    check("idle_a", {31'b0, found}, 32'd1);
  endtask

  task automatic check_start_a(input int acc);
    int s;
    s = (start_q_a.size() > 0) ? start_q_a.pop_front() : -1;
    check("first_toggle_a", s, acc + 1);
  endtask

  int k, k2, e, t0, tg;
  logic found_b;

  initial begin
    reset            = 1'b1;
    bus_a.word_in    = 16'h0000;
    bus_a.word_valid = 1'b0;
    bus_b.word_in    = 32'h0000_0000;
    bus_b.word_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_start", tx_start_a, 32'd0);
    check("rst_tx_data", tx_data_a, 32'h00);
    check("rst_frame_count", fc_a, 32'd0);
    check("rst_busy", busy_a, 32'd0);
    check("rst_ready", bus_a.word_ready, 32'd0);
    check("rst_busy_b", busy_b, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_rst", bus_a.word_ready, 32'd1);

    // Single word 1234 -> AA 12 34 26
    tg = tog_a;
    present_a(16'h1234);
    wait_accept_a(k);
    #1;
    check("busy_after_accept", busy_a, 32'd1);
    wait_idle_a(e);
    check("idle_edge_1234", e, k + 12);
    check("frame_count_1", fc_a, 32'd1);
    check("toggles_1234", tog_a - tg, 32'd4);
    check_start_a(k);
    check("queue_empty_1", exp_q_a.size(), 32'd0);

    // tx_busy held high for 100 cycles blocks acceptance
    @(negedge clk);
    #1;
    t0      = cyc;
    busy_lo = 0;
    busy_hi = t0 + 103;
    present_a(16'hC3A5);
    tg = tog_a;
    for (int i = 0; i < 100; i++) begin
      #1;
      check("ready_blocked", bus_a.word_ready, 32'd0);
      @(negedge clk);
    end
    check("no_toggle_blocked", tog_a - tg, 32'd0);
    wait_accept_a(k);
    check("accept_after_release", k, busy_hi + 1);
    busy_hi = 0;
    wait_idle_a(e);
    check_start_a(k);
    check("frame_count_2", fc_a, 32'd2);

    // Back-to-back FFFF then 0000 with the core busy window
    present_a(16'hFFFF);
    wait_accept_a(k);
    busy_lo = k + 4;
    busy_hi = k + 54;
    present_a(16'h0000);
    check_start_a(k);
    wait_accept_a(k2);
    check("b2b_accept", k2, k + 55);
    wait_idle_a(e);
    check_start_a(k2);
    check("frame_count_4", fc_a, 32'd4);
    check("queue_empty_b2b", exp_q_a.size(), 32'd0);
    busy_lo = 0;
    busy_hi = 0;

    // 32-bit instance, BYTE_GAP=5: DEADBEEF -> AA DE AD BE EF 22
    push_frame_b(32'hDEADBEEF);
    @(negedge clk);
    bus_b.word_in    = 32'hDEADBEEF;
    bus_b.word_valid = 1'b1;
    #1;
    check("ready_b", bus_b.word_ready, 32'd1);
    k = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    bus_b.word_valid = 1'b0;
    bus_b.word_in    = 32'h0000_0000;
    found_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (busy_b === 1'b0) begin
        found_b = 1'b1;
        break;
      end
    end
    check("idle_b", {31'b0, found_b}, 32'd1);
    check("frame_count_b", fc_b, 32'd1);
    check("first_toggle_b", (start_q_b.size() > 0) ? start_q_b.pop_front() : -1, k + 1);
    check("queue_empty_b", exp_q_b.size(), 32'd0);

    // Reset during the third byte's gap aborts the frame
    present_a(16'h5A3C);
    wait_accept_a(k);
    tg = tog_a;
    repeat (5) @(negedge clk);
    check("toggles_before_reset", tog_a - tg, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort_tx_start", tx_start_a, 32'd0);
    check("abort_tx_data", tx_data_a, 32'h00);
    check("abort_frame_count", fc_a, 32'd0);
    check("abort_busy", busy_a, 32'd0);
    reset = 1'b0;
    check_start_a(k);
    present_a(16'h8001);
    wait_accept_a(k);
    wait_idle_a(e);
    check("idle_edge_8001", e, k + 12);
    check_start_a(k);
    check("frame_count_after_abort", fc_a, 32'd1);
    check("queue_empty_abort", exp_q_a.size(), 32'd0);

    // frame_count wraps from FFFF to 0
    @(negedge clk);
    force dut_a.frame_count_r = 16'hFFFF;
    @(negedge clk);
    release dut_a.frame_count_r;
    #1;
    check("preload_ffff", fc_a, 32'hFFFF);
    present_a(16'h0F0F);
    wait_accept_a(k);
    wait_idle_a(e);
    check_start_a(k);
    check("frame_count_wrap", fc_a, 32'd0);
    check("queue_empty_end", exp_q_a.size(), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
